// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer.
// Accepts a cipher key over a valid/ready handshake. It then steps an external round-key
// generator through round constants 0..9 and keeps all 11 round keys in a local register file.
// The cipher core reads those keys through a port with one cycle of latency.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush_i                          synchronous abort back to idle, drops keys_ready/err
//   key_valid_i/key_ready_o, key_i   cipher key handshake (word 0 in [127:96])
//   kg_start_o/kg_rc_o/kg_key_o      request to the round-key generator
//   kg_finished_i/kg_keyout_i        generator result
//   rk_req_i/rk_idx_i                round-key read request
//   rk_valid_o/rk_miss_o/rk_o        read response, one cycle after the request
//   keys_ready_o, busy_o, err_o      status
module aes_key_sched_ctrl #(
  parameter int unsigned KG_WAIT_MAX = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [127:0] key_i,
  output logic         kg_start_o,
  output logic [3:0]   kg_rc_o,
  output logic [127:0] kg_key_o,
  input  logic         kg_finished_i,
  input  logic [127:0] kg_keyout_i,
  input  logic         rk_req_i,
  input  logic [3:0]   rk_idx_i,
  output logic         rk_valid_o,
  output logic [127:0] rk_o,
  output logic         rk_miss_o,
  output logic         keys_ready_o,
  output logic         busy_o,
  output logic         err_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StStore = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StErr   = 3'd4;

  localparam logic [4:0] WaitLast = 5'(KG_WAIT_MAX - 1);

  logic [2:0]   state_q, state_d;
  logic [3:0]   rc_q, rc_d;
  logic [4:0]   wait_q, wait_d;
  logic [127:0] cur_key_q, cur_key_d;
  logic         keys_ready_q, keys_ready_d;
  logic         err_q, err_d;

  logic [127:0] rk_q [11];
  logic         rk_wr_en;
  logic [3:0]   rk_wr_idx;
  logic [127:0] rk_wr_data;

  logic         rk_valid_q, rk_valid_d;
  logic         rk_miss_q, rk_miss_d;
  logic [127:0] rk_data_q, rk_data_d;

  // Start and rc come straight from registers, so the generator sees them stable all round.
  assign key_ready_o  = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
  assign kg_start_o   = (state_q == StRun);
  assign busy_o       = (state_q == StRun) || (state_q == StStore);
  assign kg_rc_o      = rc_q;
  assign kg_key_o     = cur_key_q;
  assign keys_ready_o = keys_ready_q;
  assign err_o        = err_q;
  assign rk_valid_o   = rk_valid_q;
  assign rk_miss_o    = rk_miss_q;
  assign rk_o         = rk_data_q;

  always_comb begin
    state_d      = state_q;
    rc_d         = rc_q;
    wait_d       = wait_q;
    cur_key_d    = cur_key_q;
    keys_ready_d = keys_ready_q;
    err_d        = err_q;
    rk_wr_en     = 1'b0;
    rk_wr_idx    = 4'd0;
    rk_wr_data   = key_i;

    if (flush_i) begin
      state_d      = StIdle;
      keys_ready_d = 1'b0;
      err_d        = 1'b0;
      wait_d       = 5'd0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (key_valid_i) begin
            rk_wr_en     = 1'b1;
            cur_key_d    = key_i;
            rc_d         = 4'd0;
            wait_d       = 5'd0;
            keys_ready_d = 1'b0;
            err_d        = 1'b0;
            state_d      = StRun;
          end
        end
        StRun: begin
          if (kg_finished_i) begin
            rk_wr_en   = 1'b1;
            rk_wr_idx  = rc_q + 4'd1;
            rk_wr_data = kg_keyout_i;
            cur_key_d  = kg_keyout_i;
            state_d    = StStore;
          end else if (wait_q == WaitLast) begin
            err_d   = 1'b1;
            state_d = StErr;
          end else begin
            wait_d = wait_q + 5'd1;
          end
        end
        StStore: begin
          // One idle cycle with start low lets the generator re-arm.
          wait_d = 5'd0;
          if (rc_q == 4'd9) begin
            keys_ready_d = 1'b1;
            state_d      = StDone;
          end else begin
            rc_d    = rc_q + 4'd1;
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Read port runs independently of the sequencer.
  always_comb begin
    rk_valid_d = rk_req_i && keys_ready_q && (rk_idx_i <= 4'd10);
    rk_miss_d  = rk_req_i && !rk_valid_d;
    rk_data_d  = '0;
    for (int i = 0; i < 11; i++) begin
      if (rk_valid_d && (rk_idx_i == 4'(i))) rk_data_d = rk_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rc_q         <= 4'd0;
      wait_q       <= 5'd0;
      cur_key_q    <= '0;
      keys_ready_q <= 1'b0;
      err_q        <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_miss_q    <= 1'b0;
      rk_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      rc_q         <= rc_d;
      wait_q       <= wait_d;
      cur_key_q    <= cur_key_d;
      keys_ready_q <= keys_ready_d;
      err_q        <= err_d;
      rk_valid_q   <= rk_valid_d;
      rk_miss_q    <= rk_miss_d;
      rk_data_q    <= rk_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      for (int i = 0; i < 11; i++) begin
        if (rk_wr_en && (rk_wr_idx == 4'(i))) rk_q[i] <= rk_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;

  localparam int unsigned KgWaitMax = 16;

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsRk1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsRk2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FipsRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush_i = 1'b0;
  logic         key_valid_i = 1'b0;
  logic         key_ready_o;
  logic [127:0] key_i = '0;
  logic         kg_start_o;
  logic [3:0]   kg_rc_o;
  logic [127:0] kg_key_o;
  logic         kg_finished_i;
  logic [127:0] kg_keyout_i;
  logic         rk_req_i = 1'b0;
  logic [3:0]   rk_idx_i = '0;
  logic         rk_valid_o;
  logic [127:0] rk_o;
  logic         rk_miss_o;
  logic         keys_ready_o;
  logic         busy_o;
  logic         err_o;

  aes_key_sched_ctrl #(.KG_WAIT_MAX(KgWaitMax)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .key_valid_i  (key_valid_i),
    .key_ready_o  (key_ready_o),
    .key_i        (key_i),
    .kg_start_o   (kg_start_o),
    .kg_rc_o      (kg_rc_o),
    .kg_key_o     (kg_key_o),
    .kg_finished_i(kg_finished_i),
    .kg_keyout_i  (kg_keyout_i),
    .rk_req_i     (rk_req_i),
    .rk_idx_i     (rk_idx_i),
    .rk_valid_o   (rk_valid_o),
    .rk_o         (rk_o),
    .rk_miss_o    (rk_miss_o),
    .keys_ready_o (keys_ready_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // ---------------- round-key generator model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, s;
    inv = 8'h00;
    if (a != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rcon;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    case (rc)
      4'd0: rcon = 8'h01;  4'd1: rcon = 8'h02;  4'd2: rcon = 8'h04;  4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;  4'd5: rcon = 8'h20;  4'd6: rcon = 8'h40;  4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;  default: rcon = 8'h36;
    endcase
    t = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  bit          gen_en = 1'b1;
  int unsigned gen_delay = 1;
  int unsigned run_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_cnt <= 0;
    else if (kg_start_o) run_cnt <= run_cnt + 1;
    else run_cnt <= 0;
  end

  assign kg_finished_i = kg_start_o && gen_en && (run_cnt == gen_delay - 1);
  assign kg_keyout_i   = kexp(kg_key_o, kg_rc_o);

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic         miss;
    logic [127:0] data;
  } rd_exp_t;

  rd_exp_t sb_q[$];

  always @(negedge clk) begin
    if (rst_n && (rk_valid_o || rk_miss_o)) begin
      if (sb_q.size() == 0) begin
        chk("rd_unexpected", {126'd0, rk_miss_o, rk_valid_o}, 128'd0);
      end else begin
        rd_exp_t e;
        e = sb_q.pop_front();
        chk("rd_miss", {127'd0, rk_miss_o}, {127'd0, e.miss});
        chk("rd_valid", {127'd0, rk_valid_o}, {127'd0, !e.miss});
        chk("rd_data", rk_o, e.data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] idx, input logic miss, input logic [127:0] data);
    rd_exp_t e;
    e.miss = miss;
    e.data = data;
    sb_q.push_back(e);
    rk_req_i = 1'b1;
    rk_idx_i = idx;
    tick();
    rk_req_i = 1'b0;
  endtask

  task automatic accept(input logic [127:0] k);
    key_i = k;
    key_valid_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
  endtask

  // Waits for keys_ready, checking the rc sequence and single-cycle start gaps on the way.
  task automatic wait_ready(input string name, input int exp_cycles);
    int n, rounds, lowlen;
    bit prev;
    n = 0; rounds = 0; lowlen = 0; prev = 1'b0;
    while (n < 200) begin
      if (kg_start_o && !prev) begin
        chk({name, "_rc"}, {124'd0, kg_rc_o}, 128'(rounds));
        if (rounds > 0) chk({name, "_gap"}, 128'(lowlen), 128'd1);
        rounds++;
      end
      lowlen = kg_start_o ? 0 : lowlen + 1;
      prev = kg_start_o;
      if (keys_ready_o) break;
      tick();
      n++;
    end
    chk({name, "_latency"}, 128'(n), 128'(exp_cycles));
    chk({name, "_rounds"}, 128'(rounds), 128'd10);
  endtask

  task automatic wait_rc(input logic [3:0] rc);
    int n;
    n = 0;
    while (!(kg_start_o && kg_rc_o == rc) && n < 200) begin
      tick();
      n++;
    end
    chk("wait_rc_bound", {127'd0, n < 200}, 128'd1);
  endtask

  initial begin
    int n;
    // Reset state.
    #12;
    chk("rst_key_ready", {127'd0, key_ready_o}, 128'd1);
    chk("rst_flags", {122'd0, kg_start_o, busy_o, keys_ready_o, err_o, rk_valid_o, rk_miss_o},
        128'd0);
    chk("rst_rc", {124'd0, kg_rc_o}, 128'd0);
    chk("rst_kg_key", kg_key_o, 128'd0);
    chk("rst_rk", rk_o, 128'd0);
    rst_n = 1'b1;
    tick();

    // Read before any key is ready.
    rd(4'd5, 1'b1, 128'd0);

    // FIPS-197 expansion, generator finishing combinationally.
    gen_en = 1'b1; gen_delay = 1;
    accept(FipsKey);
    chk("accept_busy", {127'd0, busy_o}, 128'd1);
    chk("accept_key_ready", {127'd0, key_ready_o}, 128'd0);
    wait_ready("fips", 20);
    rd(4'd0, 1'b0, FipsKey);
    rd(4'd1, 1'b0, FipsRk1);
    rd(4'd2, 1'b0, FipsRk2);
    rd(4'd10, 1'b0, FipsRk10);
    rd(4'd11, 1'b1, 128'd0);
    rd(4'd15, 1'b1, 128'd0);

    // Slow generator: three RUN cycles per round.
    gen_delay = 3;
    accept(FipsKey);
    chk("restart_clears_ready", {127'd0, keys_ready_o}, 128'd0);
    wait_ready("slow", 40);
    rd(4'd10, 1'b0, FipsRk10);

    // Timeout with finish held low.
    gen_en = 1'b0;
    accept(128'h0123456789abcdeffedcba9876543210);
    n = 0;
    while (!err_o && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 128'(n), 128'(KgWaitMax));
    chk("timeout_busy", {127'd0, busy_o}, 128'd0);
    chk("timeout_key_ready", {127'd0, key_ready_o}, 128'd1);
    chk("timeout_rc", {124'd0, kg_rc_o}, 128'd0);
    gen_en = 1'b1; gen_delay = 1;
    accept(FipsKey);
    chk("err_cleared", {127'd0, err_o}, 128'd0);
    wait_ready("after_err", 20);
    rd(4'd1, 1'b0, FipsRk1);

    // Flush during round 4.
    accept(FipsKey);
    wait_rc(4'd4);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_idle", {124'd0, key_ready_o, busy_o, kg_start_o, keys_ready_o}, 128'b1000);
    rd(4'd5, 1'b1, 128'd0);

    // Flush with a simultaneous key offer: the key must be ignored.
    key_i = FipsKey;
    key_valid_i = 1'b1;
    flush_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_vs_key", {125'd0, key_ready_o, busy_o, kg_start_o}, 128'b100);
    tick();
    chk("flush_vs_key_idle", {127'd0, busy_o}, 128'd0);

    // Asynchronous reset during round 6.
    accept(FipsKey);
    wait_rc(4'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_key_ready", {127'd0, key_ready_o}, 128'd1);
    chk("arst_flags", {122'd0, kg_start_o, busy_o, keys_ready_o, err_o, rk_valid_o, rk_miss_o},
        128'd0);
    chk("arst_rc", {124'd0, kg_rc_o}, 128'd0);
    chk("arst_kg_key", kg_key_o, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd(4'd0, 1'b1, 128'd0);
    accept(FipsKey);
    chk("rerun_rc0", {124'd0, kg_rc_o}, 128'd0);
    wait_ready("rerun", 20);
    rd(4'd10, 1'b0, FipsRk10);
    rd(4'd0, 1'b0, FipsKey);

    tick();
    tick();
    chk("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequencer for the AES-128 key-expansion round function. It accepts a cipher key over a valid/ready handshake and steps the external round-key generator through round constants 0..9, waiting on the generator's finish flag each round. It stores all 11 round keys in an internal register file and serves them to the AES cipher core through a one-cycle-latency read port. It sits between the key CSR/loader and the cipher datapath in the AES accelerator.

## Interface
- KG_WAIT_MAX, 16: maximum RUN cycles per round without `kg_finished_i` before error (1..31).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- flush_i  in  1  synchronous abort; returns to IDLE and invalidates stored keys.
- key_valid_i  in  1  cipher key offered.
- key_ready_o  out  1  block can accept a key.
- key_i  in  128  cipher key, word 0 in [127:96].
- kg_start_o  out  1  start to round-key generator.
- kg_rc_o  out  4  round-constant index to generator.
- kg_key_o  out  128  previous round key to generator.
- kg_finished_i  in  1  generator result valid.
- kg_keyout_i  in  128  next round key from generator.
- rk_req_i  in  1  round-key read request.
- rk_idx_i  in  4  round-key index, 0..10.
- rk_valid_o  out  1  read data valid (1-cycle pulse).
- rk_o  out  128  round key read data.
- rk_miss_o  out  1  read rejected (1-cycle pulse).
- keys_ready_o  out  1  all 11 round keys valid.
- busy_o  out  1  expansion in progress.
- err_o  out  1  generator timeout occurred.

## Operation
- States: IDLE, RUN, STORE, DONE, ERR.
- IDLE/DONE/ERR: `key_ready_o`=1. On `key_valid_i && key_ready_o`: rk[0]←key_i, cur_key←key_i, rc←0, wait_cnt←0, `keys_ready_o`←0, `err_o`←0 → RUN.
- RUN: `kg_start_o`=1, `kg_key_o`=cur_key, `kg_rc_o`=rc (both registered, stable for the whole round). `busy_o`=1.
  - If `kg_finished_i`=1: rk[rc+1]←kg_keyout_i, cur_key←kg_keyout_i → STORE.
  - Else wait_cnt++. When wait_cnt reaches KG_WAIT_MAX: → ERR, `err_o`←1.
- STORE: `kg_start_o`=0 for one cycle so the generator's S-boxes re-arm. wait_cnt←0.
  - rc==9: → DONE, `keys_ready_o`←1.
  - Otherwise: rc←rc+1 → RUN.
- `busy_o`=1 in RUN and STORE only. `key_ready_o`=0 in RUN and STORE. A new key is never accepted mid-expansion.
- A key accepted in DONE or ERR restarts expansion and clears `keys_ready_o`/`err_o` on the accept edge.
- Read port, independent of the FSM:
  - A request with `keys_ready_o`=1 and rk_idx_i≤10 gives `rk_valid_o`=1 and `rk_o`=rk[idx] next cycle.
  - Otherwise (idx 11..15 or keys not ready) gives `rk_miss_o`=1 and `rk_o`=0 next cycle.
- `flush_i` has priority over everything, including a simultaneous key accept. Next state is IDLE; `keys_ready_o`, `err_o`, `kg_start_o` and `busy_o` go to 0. Register-file contents are don't-care.
- Async reset is legal at any point, including mid-RUN, and yields the reset state below.

## Timing
- Reset values:
  - Outputs: `key_ready_o`=1. `kg_start_o`, `busy_o`, `keys_ready_o`, `err_o`, `rk_valid_o`, `rk_miss_o`=0. `kg_rc_o`=0, `kg_key_o`=0, `rk_o`=0.
  - Internal: state IDLE, rk[] all zero.
- Per round: F+1 cycles, where F≥1 is the RUN cycle in which `kg_finished_i` is first sampled high.
- Total latency: with the accept edge at cycle 0, `keys_ready_o` rises at the end of cycle 10·(F+1). Minimum 20 cycles, when the generator finishes combinationally in the first RUN cycle.
- Timeout: ERR is entered at the edge ending the KG_WAIT_MAX-th consecutive RUN cycle without finish.
- Read latency is exactly 1 cycle. Back-to-back requests are honoured every cycle.
- `kg_finished_i` is ignored outside RUN.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, real generator instance in bench:
  - rk[1] reads a0fafe1788542cb123a339392a6c7605.
  - rk[10] reads d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `keys_ready_o` rises 20 cycles after accept.
- Generator model delaying finish by 3 RUN cycles: latency is 40 cycles; `kg_rc_o` steps 0..9; `kg_start_o` is low exactly one cycle between rounds.
- Finish held low: `err_o`=1 after KG_WAIT_MAX RUN cycles, `busy_o`=0, `key_ready_o`=1. A new key then clears `err_o` and completes.
- Reads:
  - rk_idx_i=11 with keys ready gives `rk_miss_o` pulse and `rk_o`=0.
  - idx 5 before keys ready gives a miss.
  - idx 0 after completion returns the cipher key.
- `flush_i` in round 4 gives IDLE next cycle and `keys_ready_o`=0. `flush_i` together with `key_valid_i` in IDLE: the key is not accepted.
- `rst_n` low during round 6 clears all outputs immediately. A re-supplied key then expands correctly from rc=0.
